shift_rot_pipe: RTL and testbench

SHIFT_ROT_PIPE -- requirements
Module: shift_rot_pipe

---
 rtl/shift_rot_pipe.sv | 171 +++++++++++++++++
 tb/tb_shift_rot_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter / rotator with a valid/ready handshake on both sides.
// The log2(WIDTH) shift levels are spread over PIPE register stages. Each stage
// carries its partial result together with the sign fill, mode, shift amount,
// tag, running carry and a valid bit. The whole pipe advances in lock-step
// whenever the output slot is free or is being drained.
module shift_rot_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2,
  parameter int TAG_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH-1:0]         i_x,
  input  logic [$clog2(WIDTH)-1:0] i_s,
  input  logic [2:0]               i_mode,
  input  logic [TAG_W-1:0]         i_tag_in,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH-1:0]         o_z,
  output logic                     o_carry,
  output logic [TAG_W-1:0]         o_tag_out
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } shiftMode_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
  } levelResult_t;

  // Applies barrel levels loLevel..hiLevel-1 to a partial result. The carry is
  // re-taken at every level that actually moves bits: for any level order the
  // last such level yields X[WIDTH-S] for left moves and X[S-1] for right
  // moves, which equals Z[0] for ROL and Z[WIDTH-1] for ROR. Pass-through
  // modes never touch data or carry, so S=0 and MODE 101..111 give Z=X, C=0.
  function automatic levelResult_t runLevels(
    input logic [WIDTH-1:0] dataIn,
    input logic             carryIn,
    input logic             fill,
    input logic [2:0]       mode,
    input logic [SW-1:0]    shamt,
    input int               loLevel,
    input int               hiLevel
  );
    levelResult_t     res;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] outBits;
    logic             isLeft;
    logic             isRight;
    int               sh;
    d         = dataIn;
    res.carry = carryIn;
    isLeft    = (mode == MODE_SLL) || (mode == MODE_ROL);
    isRight   = (mode == MODE_SRL) || (mode == MODE_SRA) || (mode == MODE_ROR);
    for (int k = 0; k < SW; k++) begin
      sh      = 1 << k;
      outBits = '0;
      if ((k >= loLevel) && (k < hiLevel) && shamt[k] && (isLeft || isRight)) begin
        if (isLeft) begin
          outBits = d >> (WIDTH - sh);
        end else begin
          outBits = d >> (sh - 1);
        end
        res.carry = outBits[0];
        case (mode)
          MODE_SLL: d = d << sh;
          MODE_SRL: d = d >> sh;
          MODE_SRA: d = (d >> sh) | ({WIDTH{fill}} << (WIDTH - sh));
          MODE_ROL: d = (d << sh) | (d >> (WIDTH - sh));
          MODE_ROR: d = (d >> sh) | (d << (WIDTH - sh));
          default:  d = d;
        endcase
      end
    end
    res.data = d;
    return res;
  endfunction

  // Stage registers; index PIPE-1 is the output slot.
  logic [WIDTH-1:0] r_data  [PIPE];
  logic             r_carry [PIPE];
  logic             r_fill  [PIPE];
  logic [2:0]       r_mode  [PIPE];
  logic [SW-1:0]    r_s     [PIPE];
  logic [TAG_W-1:0] r_tag   [PIPE];
  logic             r_valid [PIPE];

  // Combinational inputs to each stage and the result of its level slice.
  logic [WIDTH-1:0] w_inData  [PIPE];
  logic             w_inCarry [PIPE];
  logic             w_inFill  [PIPE];
  logic [2:0]       w_inMode  [PIPE];
  logic [SW-1:0]    w_inS     [PIPE];
  logic [TAG_W-1:0] w_inTag   [PIPE];
  logic             w_inValid [PIPE];
  levelResult_t     w_result  [PIPE];
  logic             w_advance;

  assign o_out_valid = r_valid[PIPE-1];
  assign o_z         = r_data[PIPE-1];
  assign o_carry     = r_carry[PIPE-1];
  assign o_tag_out   = r_tag[PIPE-1];
  assign o_in_ready  = !o_out_valid || i_out_ready;
  assign w_advance   = o_in_ready;

  // Route the primary inputs into stage 0 and each stage's registers into the next.
  always_comb begin
    w_inData[0]  = i_x;
    w_inCarry[0] = 1'b0;
    w_inFill[0]  = i_x[WIDTH-1];
    w_inMode[0]  = i_mode;
    w_inS[0]     = i_s;
    w_inTag[0]   = i_tag_in;
    w_inValid[0] = i_in_valid;
    for (int p = 1; p < PIPE; p++) begin
      w_inData[p]  = r_data[p-1];
      w_inCarry[p] = r_carry[p-1];
      w_inFill[p]  = r_fill[p-1];
      w_inMode[p]  = r_mode[p-1];
      w_inS[p]     = r_s[p-1];
      w_inTag[p]   = r_tag[p-1];
      w_inValid[p] = r_valid[p-1];
    end
  end

  // Each stage runs its own contiguous slice of levels; slices differ by at most one level.
  always_comb begin
    for (int p = 0; p < PIPE; p++) begin
      w_result[p] = runLevels(w_inData[p], w_inCarry[p], w_inFill[p], w_inMode[p],
                              w_inS[p], (p * SW) / PIPE, ((p + 1) * SW) / PIPE);
    end
  end

  // Lock-step advance; bubbles clear valid but keep the old payload so idle inputs never reach the outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < PIPE; p++) begin
        r_valid[p] <= 1'b0;
        r_data[p]  <= '0;
        r_carry[p] <= 1'b0;
        r_fill[p]  <= 1'b0;
        r_mode[p]  <= '0;
        r_s[p]     <= '0;
        r_tag[p]   <= '0;
      end
    end else if (w_advance) begin
      for (int p = 0; p < PIPE; p++) begin
        r_valid[p] <= w_inValid[p];
        if (w_inValid[p]) begin
          r_data[p]  <= w_result[p].data;
          r_carry[p] <= w_result[p].carry;
          r_fill[p]  <= w_inFill[p];
          r_mode[p]  <= w_inMode[p];
          r_s[p]     <= w_inS[p];
          r_tag[p]   <= w_inTag[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Directed testbench for shift_rot_pipe (WIDTH=32, PIPE=2, TAG_W=4):
// a vector table of single operations plus hand sequences for stall,
// idle-input isolation and mid-flight reset.
module tb_shift_rot_pipe;

  typedef struct {
    logic [31:0] x;
    logic [4:0]  s;
    logic [2:0]  mode;
    logic [3:0]  tag;
    logic [31:0] expZ;
    logic        expCarry;
  } vector_t;

  localparam int NVEC = 19;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] x;
  logic [4:0]  s;
  logic [2:0]  mode;
  logic [3:0]  tagIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] z;
  logic        carry;
  logic [3:0]  tagOut;

  int checks   = 0;
  int failures = 0;

  vector_t vectors [NVEC];

  logic [31:0] opX    [4];
  logic [4:0]  opS    [4];
  logic [3:0]  opTag  [4];
  logic [31:0] opZ    [4];
  logic        opC    [4];

  shift_rot_pipe #(.WIDTH(32), .PIPE(2), .TAG_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_x         (x),
    .i_s         (s),
    .i_mode      (mode),
    .i_tag_in    (tagIn),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_z         (z),
    .o_carry     (carry),
    .o_tag_out   (tagOut)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] xv, input logic [4:0] sv,
                               input logic [2:0] mv, input logic [3:0] tv);
    inValid = v;
    x       = xv;
    s       = sv;
    mode    = mv;
    tagIn   = tv;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  initial begin
    int sent;
    int got;
    int stallLeft;
    bit stallStarted;
    bit stallNow;

    vectors[0]  = '{32'h0000_0001, 5'd31, 3'b000, 4'd3,  32'h8000_0000, 1'b0};
    vectors[1]  = '{32'h8000_00F0, 5'd4,  3'b010, 4'd4,  32'hF800_000F, 1'b0};
    vectors[2]  = '{32'h0000_00F0, 5'd5,  3'b001, 4'd5,  32'h0000_0007, 1'b1};
    vectors[3]  = '{32'h0000_0001, 5'd1,  3'b100, 4'd6,  32'h8000_0000, 1'b1};
    vectors[4]  = '{32'h8000_0000, 5'd1,  3'b011, 4'd7,  32'h0000_0001, 1'b1};
    vectors[5]  = '{32'hDEAD_BEEF, 5'd0,  3'b111, 4'd8,  32'hDEAD_BEEF, 1'b0};
    vectors[6]  = '{32'hDEAD_BEEF, 5'd7,  3'b101, 4'd9,  32'hDEAD_BEEF, 1'b0};
    vectors[7]  = '{32'hDEAD_BEEF, 5'd0,  3'b000, 4'd10, 32'hDEAD_BEEF, 1'b0};
    vectors[8]  = '{32'hDEAD_BEEF, 5'd0,  3'b011, 4'd11, 32'hDEAD_BEEF, 1'b0};
    vectors[9]  = '{32'h1234_5678, 5'd4,  3'b000, 4'd12, 32'h2345_6780, 1'b1};
    vectors[10] = '{32'h7FFF_FFFF, 5'd31, 3'b010, 4'd13, 32'h0000_0000, 1'b1};
    vectors[11] = '{32'h8000_0000, 5'd31, 3'b010, 4'd14, 32'hFFFF_FFFF, 1'b0};
    vectors[12] = '{32'h1234_5678, 5'd8,  3'b011, 4'd15, 32'h3456_7812, 1'b0};
    vectors[13] = '{32'h1234_5678, 5'd4,  3'b100, 4'd0,  32'h8123_4567, 1'b1};
    vectors[14] = '{32'hFFFF_FFFF, 5'd31, 3'b001, 4'd1,  32'h0000_0001, 1'b1};
    vectors[15] = '{32'hFFFF_FFFF, 5'd16, 3'b000, 4'd2,  32'hFFFF_0000, 1'b1};
    vectors[16] = '{32'h8000_0001, 5'd31, 3'b011, 4'd3,  32'hC000_0000, 1'b0};
    vectors[17] = '{32'hA5A5_0001, 5'd3,  3'b110, 4'd4,  32'hA5A5_0001, 1'b0};
    vectors[18] = '{32'h0000_000F, 5'd16, 3'b100, 4'd5,  32'h000F_0000, 1'b0};

    opX[0] = 32'h0000_0001; opS[0] = 5'd0; opTag[0] = 4'd8;  opZ[0] = 32'h0000_0001; opC[0] = 1'b0;
    opX[1] = 32'h0000_0002; opS[1] = 5'd1; opTag[1] = 4'd9;  opZ[1] = 32'h0000_0004; opC[1] = 1'b0;
    opX[2] = 32'h0000_0003; opS[2] = 5'd2; opTag[2] = 4'd10; opZ[2] = 32'h0000_000C; opC[2] = 1'b0;
    opX[3] = 32'hF000_0000; opS[3] = 5'd4; opTag[3] = 4'd11; opZ[3] = 32'h0000_0000; opC[3] = 1'b1;

    rstN     = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, 3'b000, 4'd0);

    // Reset values before any clock edge.
    #2;
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset z", 64'(z), 64'd0);
    checkOutput("reset carry", 64'(carry), 64'd0);
    checkOutput("reset tag", 64'(tagOut), 64'd0);
    checkOutput("reset in_ready", 64'(inReady), 64'd1);

    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    // Table: one operation at a time, result checked PIPE edges after it is offered.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b1, vectors[i].x, vectors[i].s, vectors[i].mode, vectors[i].tag);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 5'd0, 3'b000, 4'd0);
      if (i == 0) checkOutput("latency not early", 64'(outValid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid", i), 64'(outValid), 64'd1);
      checkOutput($sformatf("vec%0d z", i), 64'(z), 64'(vectors[i].expZ));
      checkOutput($sformatf("vec%0d carry", i), 64'(carry), 64'(vectors[i].expCarry));
      checkOutput($sformatf("vec%0d tag", i), 64'(tagOut), 64'(vectors[i].tag));
    end

    // Idle inputs with junk must not disturb outputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, $urandom, 5'($urandom), 3'($urandom), 4'($urandom));
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle valid", 64'(outValid), 64'd0);
      checkOutput("idle z held", 64'(z), 64'(vectors[NVEC-1].expZ));
    end

    // Back-to-back ops with the consumer stalled for 3 cycles after the first result.
    sent = 0;
    got = 0;
    stallLeft = 0;
    stallStarted = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      stallNow = 0;
      if (outValid) begin
        if (!stallStarted) begin
          stallStarted = 1;
          stallLeft = 3;
        end
        stallNow = (stallLeft > 0);
      end
      outReady = !stallNow;
      if (sent < 4) applyStimulus(1'b1, opX[sent], opS[sent], 3'b000, opTag[sent]);
      else applyStimulus(1'b0, 32'h0, 5'd0, 3'b000, 4'd0);
      #1;
      if (stallNow) begin
        checkOutput("stall in_ready", 64'(inReady), 64'd0);
        checkOutput("stall z stable", 64'(z), 64'(opZ[got]));
        checkOutput("stall tag stable", 64'(tagOut), 64'(opTag[got]));
        stallLeft--;
      end else if (outValid) begin
        checkOutput($sformatf("stream%0d z", got), 64'(z), 64'(opZ[got]));
        checkOutput($sformatf("stream%0d carry", got), 64'(carry), 64'(opC[got]));
        checkOutput($sformatf("stream%0d tag", got), 64'(tagOut), 64'(opTag[got]));
        got++;
      end
      if (inValid && inReady) sent++;
    end
    checkOutput("stream results count", 64'(got), 64'd4);
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5'd0, 3'b000, 4'd0);
    checkOutput("stream no duplicate", 64'(outValid), 64'd0);

    // Reset pulse between edges with two operations in flight.
    applyStimulus(1'b1, 32'h0000_0005, 5'd1, 3'b000, 4'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0006, 5'd2, 3'b000, 4'd2);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(outValid), 64'd0);
    checkOutput("midreset z", 64'(z), 64'd0);
    checkOutput("midreset carry", 64'(carry), 64'd0);
    checkOutput("midreset tag", 64'(tagOut), 64'd0);
    checkOutput("midreset in_ready", 64'(inReady), 64'd1);
    #1 rstN = 1'b1;
    applyStimulus(1'b1, 32'h0000_0003, 5'd1, 3'b100, 4'hA);
    @(negedge clk);
    checkOutput("post-reset empty", 64'(outValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5'd0, 3'b000, 4'd0);
    checkOutput("post-reset discard", 64'(outValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset op valid", 64'(outValid), 64'd1);
    checkOutput("post-reset op z", 64'(z), 64'h8000_0001);
    checkOutput("post-reset op carry", 64'(carry), 64'd1);
    checkOutput("post-reset op tag", 64'(tagOut), 64'hA);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset drained", 64'(outValid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
